// File: rtl/alarm_trigger.sv
// Alarm trigger control: compares time of day to alarm time and pulses start/stop to the tone generator.
// Optional ring timeout enabled by defining RING_TIMEOUT_EN.
module alarm_trigger #(
    parameter int unsigned CLK_HZ           = 62500000,
    parameter int unsigned SNOOZE_SEC       = 300,
    parameter int unsigned MAX_SNOOZE       = 3,
    parameter int unsigned RING_TIMEOUT_SEC = 600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alarm_en,
    input  logic [4:0] cur_hh,
    input  logic [5:0] cur_mm,
    input  logic [4:0] alm_hh,
    input  logic [5:0] alm_mm,
    input  logic       snooze_btn,
    input  logic       dismiss_btn,
    output logic       start,
    output logic       stop,
    output logic       ringing,
    output logic       snoozing,
    output logic [1:0] snooze_count
);

    localparam int unsigned PW      = $clog2(CLK_HZ + 1);
    localparam int unsigned SEC_MAX = (SNOOZE_SEC > RING_TIMEOUT_SEC) ? SNOOZE_SEC : RING_TIMEOUT_SEC;
    localparam int unsigned SW      = $clog2(SEC_MAX + 1);

    typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_t;

    state_t          state;
    logic [PW-1:0]   presc;
    logic [SW-1:0]   sec_cnt;
    logic [SW-1:0]   sec_next;
    logic            match;
    logic            match_q;
    logic            trigger;
    logic            running;
    logic            tick;
    logic            snz_done;
    logic            tmo;

    // Interval ends are detected on the tick that completes the final second,
    // so re-ring/timeout land exactly N*CLK_HZ cycles after the causing edge.
    always_comb begin
        match    = (cur_hh == alm_hh) && (cur_mm == alm_mm);
        trigger  = match && !match_q;
        running  = (state == RINGING) || (state == SNOOZE);
        tick     = running && (presc == PW'(CLK_HZ - 1));
        sec_next = sec_cnt + 1'b1;
        snz_done = tick && (sec_next == SW'(SNOOZE_SEC));
`ifdef RING_TIMEOUT_EN
        tmo      = tick && (sec_next == SW'(RING_TIMEOUT_SEC));
`else
        tmo      = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            presc        <= '0;
            sec_cnt      <= '0;
            match_q      <= 1'b0;
            start        <= 1'b0;
            stop         <= 1'b0;
            ringing      <= 1'b0;
            snoozing     <= 1'b0;
            snooze_count <= '0;
        end else begin
            start   <= 1'b0;
            stop    <= 1'b0;
            match_q <= match;

            if (running) begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick)
                    sec_cnt <= sec_next;
            end else begin
                presc   <= '0;
                sec_cnt <= '0;
            end

            if (!alarm_en) begin
                if (state == RINGING)
                    stop <= 1'b1;
                state        <= IDLE;
                ringing      <= 1'b0;
                snoozing     <= 1'b0;
                snooze_count <= '0;
            end else begin
                case (state)
                    IDLE: state <= ARMED;
                    ARMED: begin
                        if (trigger) begin
                            state        <= RINGING;
                            start        <= 1'b1;
                            ringing      <= 1'b1;
                            snooze_count <= '0;
                            presc        <= '0;
                            sec_cnt      <= '0;
                        end
                    end
                    RINGING: begin
                        if (dismiss_btn) begin
                            state        <= ARMED;
                            stop         <= 1'b1;
                            ringing      <= 1'b0;
                            snooze_count <= '0;
                        end else if (snooze_btn && (snooze_count < 2'(MAX_SNOOZE))) begin
                            state        <= SNOOZE;
                            stop         <= 1'b1;
                            ringing      <= 1'b0;
                            snoozing     <= 1'b1;
                            snooze_count <= snooze_count + 1'b1;
                            presc        <= '0;
                            sec_cnt      <= '0;
                        end else if (tmo) begin
                            state        <= ARMED;
                            stop         <= 1'b1;
                            ringing      <= 1'b0;
                            snooze_count <= '0;
                        end
                    end
                    SNOOZE: begin
                        if (dismiss_btn) begin
                            state        <= ARMED;
                            snoozing     <= 1'b0;
                            snooze_count <= '0;
                        end else if (snz_done) begin
                            state    <= RINGING;
                            start    <= 1'b1;
                            ringing  <= 1'b1;
                            snoozing <= 1'b0;
                            presc    <= '0;
                            sec_cnt  <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger: CLK_HZ=10, SNOOZE_SEC=3, MAX_SNOOZE=2, RING_TIMEOUT_SEC=2.
module tb_alarm_trigger;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alarm_en;
    logic [4:0] cur_hh;
    logic [5:0] cur_mm;
    logic [4:0] alm_hh;
    logic [5:0] alm_mm;
    logic       snooze_btn;
    logic       dismiss_btn;
    logic       start;
    logic       stop;
    logic       ringing;
    logic       snoozing;
    logic [1:0] snooze_count;

    int vectors    = 0;
    int miscompares = 0;

    alarm_trigger #(
        .CLK_HZ(10),
        .SNOOZE_SEC(3),
        .MAX_SNOOZE(2),
        .RING_TIMEOUT_SEC(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .alarm_en(alarm_en),
        .cur_hh(cur_hh),
        .cur_mm(cur_mm),
        .alm_hh(alm_hh),
        .alm_mm(alm_mm),
        .snooze_btn(snooze_btn),
        .dismiss_btn(dismiss_btn),
        .start(start),
        .stop(stop),
        .ringing(ringing),
        .snoozing(snoozing),
        .snooze_count(snooze_count)
    );

    always #5 clk = ~clk;

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    // Leave and re-enter 07:30 from ARMED; the re-entry edge must fire start.
    task automatic ring_up(input string tag);
        cur_mm = 6'd31;
        clk_step();
        cur_mm = 6'd30;
        clk_step();
        vectors++;
        if (start !== 1'b1 || ringing !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_start: start=%b ringing=%b expected 1 1", tag, start, ringing);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; alarm_en = 1'b1; cur_hh = 5'd7; cur_mm = 6'd29;
        alm_hh = 5'd7; alm_mm = 6'd30; snooze_btn = 1'b0; dismiss_btn = 1'b0;
        clk_step();
        clk_step();
        vectors++;
        if ({start, stop, ringing, snoozing, snooze_count} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {start, stop, ringing, snoozing, snooze_count});
        end
        @(negedge clk);
        rst_n = 1'b1;
        clk_step();   // IDLE -> ARMED
        clk_step();
    endtask

    task automatic test_ring_start();
        cur_mm = 6'd30;
        clk_step();
        vectors++;
        if (start !== 1'b1 || ringing !== 1'b1 || stop !== 1'b0) begin
            miscompares++;
            $display("FAIL first_start: start=%b ringing=%b stop=%b expected 1 1 0", start, ringing, stop);
        end
        for (int i = 0; i < 6; i++) begin
            clk_step();
            vectors++;
            if (start !== 1'b0 || ringing !== 1'b1) begin
                miscompares++;
                $display("FAIL hold_minute: start=%b ringing=%b expected 0 1", start, ringing);
            end
        end
    endtask

    task automatic test_dismiss();
        dismiss_btn = 1'b1;
        clk_step();
        dismiss_btn = 1'b0;
        vectors++;
        if (stop !== 1'b1 || ringing !== 1'b0 || start !== 1'b0) begin
            miscompares++;
            $display("FAIL dismiss_stop: stop=%b ringing=%b start=%b expected 1 0 0", stop, ringing, start);
        end
        clk_step();
        vectors++;
        if (stop !== 1'b0 || start !== 1'b0) begin
            miscompares++;
            $display("FAIL dismiss_after: stop=%b start=%b expected 0 0", stop, start);
        end
        ring_up("rering");
    endtask

    task automatic test_snooze();
        int n;
        snooze_btn = 1'b1;
        clk_step();
        snooze_btn = 1'b0;
        vectors++;
        if (stop !== 1'b1 || snoozing !== 1'b1 || ringing !== 1'b0 || snooze_count !== 2'd1) begin
            miscompares++;
            $display("FAIL snooze_enter: stop=%b snoozing=%b ringing=%b count=%0d expected 1 1 0 1",
                     stop, snoozing, ringing, snooze_count);
        end
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            clk_step();
            if (start === 1'b1) begin
                n = i;
                break;
            end
        end
        vectors++;
        if (n != 30) begin
            miscompares++;
            $display("FAIL snooze_rering_delay: got %0d cycles expected 30", n);
        end
        vectors++;
        if (ringing !== 1'b1 || snoozing !== 1'b0 || snooze_count !== 2'd1) begin
            miscompares++;
            $display("FAIL snooze_rering_state: ringing=%b snoozing=%b count=%0d expected 1 0 1",
                     ringing, snoozing, snooze_count);
        end
    endtask

    task automatic test_max_snooze();
        snooze_btn = 1'b1;
        clk_step();
        snooze_btn = 1'b0;
        vectors++;
        if (snooze_count !== 2'd2 || snoozing !== 1'b1) begin
            miscompares++;
            $display("FAIL second_snooze: count=%0d snoozing=%b expected 2 1", snooze_count, snoozing);
        end
        repeat (30) clk_step();
        vectors++;
        if (ringing !== 1'b1) begin
            miscompares++;
            $display("FAIL second_rering: ringing=%b expected 1", ringing);
        end
        snooze_btn = 1'b1;
        clk_step();
        snooze_btn = 1'b0;
        vectors++;
        if (ringing !== 1'b1 || stop !== 1'b0 || snoozing !== 1'b0 || snooze_count !== 2'd2) begin
            miscompares++;
            $display("FAIL snooze_at_limit: ringing=%b stop=%b snoozing=%b count=%0d expected 1 0 0 2",
                     ringing, stop, snoozing, snooze_count);
        end
        snooze_btn = 1'b1;
        dismiss_btn = 1'b1;
        clk_step();
        snooze_btn = 1'b0;
        dismiss_btn = 1'b0;
        vectors++;
        if (stop !== 1'b1 || ringing !== 1'b0 || snoozing !== 1'b0 || snooze_count !== 2'd0) begin
            miscompares++;
            $display("FAIL dismiss_over_snooze: stop=%b ringing=%b snoozing=%b count=%0d expected 1 0 0 0",
                     stop, ringing, snoozing, snooze_count);
        end
    endtask

    task automatic test_snooze_dismiss();
        ring_up("snz_dismiss");
        snooze_btn = 1'b1;
        clk_step();
        snooze_btn = 1'b0;
        clk_step();
        dismiss_btn = 1'b1;
        clk_step();
        dismiss_btn = 1'b0;
        vectors++;
        if (stop !== 1'b0 || start !== 1'b0 || snoozing !== 1'b0 || snooze_count !== 2'd0) begin
            miscompares++;
            $display("FAIL dismiss_in_snooze: stop=%b start=%b snoozing=%b count=%0d expected 0 0 0 0",
                     stop, start, snoozing, snooze_count);
        end
        repeat (40) clk_step();
        vectors++;
        if (ringing !== 1'b0) begin
            miscompares++;
            $display("FAIL no_rering_after_dismiss: ringing=%b expected 0", ringing);
        end
    endtask

    task automatic test_enable_drop();
        ring_up("en_drop");
        alarm_en = 1'b0;
        clk_step();
        vectors++;
        if (stop !== 1'b1 || ringing !== 1'b0) begin
            miscompares++;
            $display("FAIL disable_ringing: stop=%b ringing=%b expected 1 0", stop, ringing);
        end
        alarm_en = 1'b1;   // still inside 07:30
        for (int i = 0; i < 5; i++) begin
            clk_step();
            vectors++;
            if (start !== 1'b0 || ringing !== 1'b0) begin
                miscompares++;
                $display("FAIL enable_in_minute: start=%b ringing=%b expected 0 0", start, ringing);
            end
        end
        ring_up("en_snz");
        snooze_btn = 1'b1;
        clk_step();
        snooze_btn = 1'b0;
        alarm_en = 1'b0;
        clk_step();
        vectors++;
        if (stop !== 1'b0 || snoozing !== 1'b0 || snooze_count !== 2'd0) begin
            miscompares++;
            $display("FAIL disable_snoozing: stop=%b snoozing=%b count=%0d expected 0 0 0",
                     stop, snoozing, snooze_count);
        end
        alarm_en = 1'b1;
        clk_step();
    endtask

    task automatic test_timeout();
        int n;
        ring_up("timeout");
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            clk_step();
            if (stop === 1'b1) begin
                n = i;
                break;
            end
        end
`ifdef RING_TIMEOUT_EN
        vectors++;
        if (n != 20 || ringing !== 1'b0) begin
            miscompares++;
            $display("FAIL ring_timeout: stop after %0d ringing=%b expected 20 0", n, ringing);
        end
`else
        vectors++;
        if (n != 0 || ringing !== 1'b1) begin
            miscompares++;
            $display("FAIL no_timeout: stop after %0d ringing=%b expected none 1", n, ringing);
        end
`endif
    endtask

    task automatic test_reset_mid_ring();
        if (ringing !== 1'b1)
            ring_up("mid_reset");
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({start, stop, ringing, snoozing, snooze_count} !== 6'b0) begin
            miscompares++;
            $display("FAIL async_reset: got %b expected 000000",
                     {start, stop, ringing, snoozing, snooze_count});
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_ring_start();
        test_dismiss();
        test_snooze();
        test_max_snooze();
        test_snooze_dismiss();
        test_enable_drop();
        test_timeout();
        test_reset_mid_ring();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
